// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
package imem_pkg;

  // Fault codes carried alongside each fetch response.
  localparam logic [1:0] IM_ERR_NONE  = 2'd0;
  localparam logic [1:0] IM_ERR_MISAL = 2'd1;
  localparam logic [1:0] IM_ERR_RANGE = 2'd2;

  // CLEAR sweeps FILL_WORD through the array; RUN serves fetches and loads.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } imem_state_t;

  // Misalignment is reported in preference to an out-of-range address.
  function automatic logic [1:0] pick_err(input logic misal, input logic out_of_range);
    if (misal) begin
      return IM_ERR_MISAL;
    end
    if (out_of_range) begin
      return IM_ERR_RANGE;
    end
    return IM_ERR_NONE;
  endfunction

endpackage

// File: rtl/imem_sync_if.sv
// Fetch, program-load and maintenance signals of the instruction memory.
interface imem_sync_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              fe_req;
  logic [ADDR_W-1:0] fe_addr;
  logic              fe_ready;
  logic              fe_rvalid;
  logic [DATA_W-1:0] fe_rdata;
  logic              fe_err;
  logic [1:0]        fe_err_code;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ready;
  logic              ld_err;

  logic              inv;
  logic              clr_busy;

  // The core / loader side.
  modport master (
    output fe_req, fe_addr, ld_we, ld_addr, ld_wdata, inv,
    input  fe_ready, fe_rvalid, fe_rdata, fe_err, fe_err_code,
    input  ld_ready, ld_err, clr_busy
  );

  // The memory side.
  modport slave (
    input  fe_req, fe_addr, ld_we, ld_addr, ld_wdata, inv,
    output fe_ready, fe_rvalid, fe_rdata, fe_err, fe_err_code,
    output ld_ready, ld_err, clr_busy
  );

endinterface

// File: rtl/imem_resp_pipe.sv
// Response pipeline: READ_LAT stages of {valid, data, err, code}.
// Stage 0 takes its data from the array's registered read output, so the
// first stage only registers the metadata; later stages register all fields.
// Data/err/code only advance with a valid response, so the outputs hold their
// last values between responses.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                READ_LAT  = 1,   // 1 or 2
  parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [1:0]        in_code,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [1:0]        out_code
);

  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_stage
      logic              valid_reg;
      logic              err_reg;
      logic [1:0]        code_reg;
      logic [DATA_W-1:0] data;

      if (gi == 0) begin : g_first
        // seen_reg keeps the un-reset read register from reaching the output before any response
        logic seen_reg;

        // Capture metadata of the fetch accepted at this edge
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= IM_ERR_NONE;
            seen_reg  <= 1'b0;
          end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
              err_reg  <= in_err;
              code_reg <= in_code;
              seen_reg <= 1'b1;
            end
          end
        end

        // Faulting fetches never read the array and return the fill word instead
        assign data = !seen_reg ? '0 : (err_reg ? FILL_WORD : ram_q);
      end else begin : g_next
        logic [DATA_W-1:0] data_reg;

        // Shift the previous stage forward when it holds a response
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            code_reg  <= IM_ERR_NONE;
            data_reg  <= '0;
          end else begin
            valid_reg <= g_stage[gi-1].valid_reg;
            if (g_stage[gi-1].valid_reg) begin
              err_reg  <= g_stage[gi-1].err_reg;
              code_reg <= g_stage[gi-1].code_reg;
              data_reg <= g_stage[gi-1].data;
            end
          end
        end

        assign data = data_reg;
      end
    end
  endgenerate

  assign out_valid = g_stage[READ_LAT-1].valid_reg;
  assign out_data  = g_stage[READ_LAT-1].data;
  assign out_err   = g_stage[READ_LAT-1].err_reg;
  assign out_code  = g_stage[READ_LAT-1].code_reg;

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory for the multicycle MIPS core.
// Fetch port with req/ready and READ_LAT-cycle pipelined responses, a program
// load port that takes priority over fetch, address fault checking, and a
// hardware clear sweep after reset or an invalidate pulse.
module imem_sync
  import imem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,           // power of 2, >= 2
  parameter int                READ_LAT  = 1,            // 1 or 2
  parameter logic [DATA_W-1:0] FILL_WORD = 32'h00000000  // sll $0,$0,0
) (
  input  logic      clk,
  input  logic      rst_n,
  imem_sync_if.slave bus
);

  localparam int               IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);

  imem_state_t      state_reg, state_next;
  logic [IDX_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic             ld_err_reg;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q_reg;

  logic              fe_rdy, ld_rdy, busy;
  logic              fe_acc, ld_acc, fe_rd;
  logic [1:0]        fe_code, ld_code;
  logic [IDX_W-1:0]  fe_idx, ld_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Fault classification of a byte address
  function automatic logic [1:0] addr_code(input logic [ADDR_W-1:0] a);
    return pick_err(a[1:0] != 2'b00, {1'b0, a} >= ADDR_LIMIT);
  endfunction

  assign fe_idx  = bus.fe_addr[IDX_W+1:2];
  assign ld_idx  = bus.ld_addr[IDX_W+1:2];
  assign fe_code = addr_code(bus.fe_addr);
  assign ld_code = addr_code(bus.ld_addr);

  assign fe_acc = bus.fe_req && fe_rdy;
  assign ld_acc = bus.ld_we && ld_rdy;
  assign fe_rd  = fe_acc && (fe_code == IM_ERR_NONE);

  // State and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next state: sweep every word once, invalidate restarts the sweep from word 0
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (bus.inv) begin
          clr_cnt_next = '0;
        end else if (clr_cnt_reg == LAST_IDX) begin
          state_next   = RUN;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        if (bus.inv) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  // Port readiness: nothing is accepted during the sweep, and a load blocks fetch
  always_comb begin
    fe_rdy = 1'b0;
    ld_rdy = 1'b0;
    busy   = 1'b1;
    if (state_reg == RUN) begin
      ld_rdy = 1'b1;
      fe_rdy = !bus.ld_we;
      busy   = 1'b0;
    end
  end

  // Single write port shared by the sweep and valid program loads
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_reg;
    mem_wdata = FILL_WORD;
    if (state_reg == CLEAR) begin
      mem_we = 1'b1;
    end else if (ld_acc && (ld_code == IM_ERR_NONE)) begin
      mem_we    = 1'b1;
      mem_waddr = ld_idx;
      mem_wdata = bus.ld_wdata;
    end
  end

  // Array write and registered read; contents are not reset, the sweep initialises them
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (fe_rd) begin
      ram_q_reg <= mem[fe_idx];
    end
  end

  // One-cycle error pulse for a dropped load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err_reg <= 1'b0;
    end else begin
      ld_err_reg <= ld_acc && (ld_code != IM_ERR_NONE);
    end
  end

  imem_resp_pipe #(
    .DATA_W    (DATA_W),
    .READ_LAT  (READ_LAT),
    .FILL_WORD (FILL_WORD)
  ) u_resp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fe_acc),
    .in_err    (fe_code != IM_ERR_NONE),
    .in_code   (fe_code),
    .ram_q     (ram_q_reg),
    .out_valid (bus.fe_rvalid),
    .out_data  (bus.fe_rdata),
    .out_err   (bus.fe_err),
    .out_code  (bus.fe_err_code)
  );

  assign bus.fe_ready = fe_rdy;
  assign bus.ld_ready = ld_rdy;
  assign bus.ld_err   = ld_err_reg;
  assign bus.clr_busy = busy;

endmodule
